activation_quant: RTL
=====================

Name: activation_quant

Overview:
- Downstream stage of the fully-connected layer block: consumes the layer's packed 2*DATAWIDTH-wide pre-activation outputs on its done pulse.
- Applies the activation (ReLU or identity), rescales with rounding, and saturates to DATAWIDTH. Produces the packed DATAWIDTH-wide activation vector that feeds the next layer's values input.
- Also tracks the argmax of the quantized results, used for output-layer classification.
- Processes one row per cycle and holds its result under a valid/ready handshake.

Parameters:
- ROWS, 30, number of neurons (elements in the input vector)
- DATAWIDTH, 11, output element width; input element width is 2*DATAWIDTH
- FRAC_SHIFT, 5, arithmetic right shift applied after activation (0 = no shift, no rounding)
- ACT_RELU, 1, 1 = ReLU, 0 = identity

Ports:
- clk  input  1  clock
- rst_overall  input  1  reset, asynchronous, active-high
- rst_vals  input  1  synchronous active-high clear of state and outputs
- in_values  input  ROWS*2*DATAWIDTH  signed pre-activations; row k at [(ROWS-k-1)*2*DATAWIDTH +: 2*DATAWIDTH]
- in_valid  input  1  input vector valid (driven by the layer's done pulse)
- in_ready  output  1  block can accept a vector
- out_values  output  ROWS*DATAWIDTH  signed activations; row k at [(ROWS-k-1)*DATAWIDTH +: DATAWIDTH]
- out_valid  output  1  out_values/argmax valid
- out_ready  input  1  consumer accepts result
- argmax_idx  output  $clog2(ROWS)  index of the maximum quantized activation
- max_value  output  DATAWIDTH  the maximum quantized activation value

Behaviour:
- Reset (rst_overall async, or rst_vals at a clock edge):
  - state=IDLE; out_values=0, out_valid=0, argmax_idx=0, max_value=0.
  - Internal buffer and row counter cleared.
  - Either reset mid-operation aborts the vector silently.
  - in_ready reflects IDLE (=1) in the first cycle after reset release.
- State machine:
  - IDLE: in_ready=1. If in_valid=1 at a clock edge, capture in_values into the buffer, set row=0, go to PROCESS.
  - PROCESS: in_ready=0. Each cycle, compute row `row`, write it into out_values, and update the running max; then row++.
  - After row ROWS-1 is written, go to HOLD.
  - HOLD: out_valid=1; out_values/argmax_idx/max_value stable. When out_ready=1 at a clock edge, set out_valid=0 and go to IDLE.
- Latency:
  - Acceptance edge T; rows are written at edges T+1..T+ROWS.
  - out_valid=1 from edge T+ROWS+1.
  - If out_ready is already 1, out_valid is high for exactly one cycle.
- Simultaneous events and input timing:
  - in_valid outside IDLE is ignored; no queuing. The upstream done pulse must arrive in IDLE.
  - in_valid and out_ready both high while in HOLD: the result is released and the new vector is NOT captured (capture happens only in IDLE).
  - in_values is sampled only at the acceptance edge; later changes have no effect.
- Per-element arithmetic, on signed 2*DATAWIDTH input x:
  - a = (ACT_RELU && x<0) ? 0 : x.
  - If FRAC_SHIFT>0: s = (a + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, computed in 2*DATAWIDTH+1 bits so the add cannot overflow. Otherwise s = a.
  - Saturate s to [-(2^(DATAWIDTH-1)), 2^(DATAWIDTH-1)-1].
- Argmax:
  - Row 0 initialises max_value/argmax_idx.
  - A later row replaces them only if strictly greater, so ties keep the lowest index.
- out_values may be observed changing during PROCESS; only the HOLD contents are architecturally valid.

Test Plan (ROWS=4, DATAWIDTH=11, FRAC_SHIFT=5):
- ReLU; rows {100, -100, 100000, 16}; pulse in_valid, out_ready=1:
  - out_valid rises exactly 5 edges after acceptance, for 1 cycle.
  - out = {3, 0, 1023, 1}; argmax_idx=2; max_value=1023.
- ACT_RELU=0; rows {-100, -100000, -16, -17}:
  - out = {-3, -1024, 0, -1}; argmax_idx=2; max_value=0.
- Ties: ReLU, rows {64, 64, 32, 64}:
  - out = {2, 2, 1, 2}; argmax_idx=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid:
  - out_valid and values held stable, in_ready=0.
  - An in_valid pulse during HOLD is ignored.
  - Raise out_ready: out_valid drops next edge, in_ready=1.
- Reset mid-PROCESS:
  - Assert rst_overall asynchronously at row 2: outputs go 0 immediately and in_ready=1 after release.
  - Repeat with rst_vals: same result at the next edge.
  - A new vector then processes correctly.
- Back-to-back: second in_valid pulse one cycle after the first release is accepted and produces correct outputs.

Source files
------------

// File: rtl/activation_quant_if.sv
// Bus bundle for activation_quant: the input-vector handshake and the
// result/argmax handshake. master = the side driving vectors and accepting
// results, slave = the activation/quantizer block itself.
interface activation_quant_if #(
  parameter int ROWS      = 30,
  parameter int DATAWIDTH = 11
);
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [ROWS*2*DATAWIDTH-1:0] in_values;
  logic                        in_valid;
  logic                        in_ready;
  logic [ROWS*DATAWIDTH-1:0]   out_values;
  logic                        out_valid;
  logic                        out_ready;
  logic [IDX_W-1:0]            argmax_idx;
  logic [DATAWIDTH-1:0]        max_value;

  modport master (
    output in_values, in_valid, out_ready,
    input  in_ready, out_values, out_valid, argmax_idx, max_value
  );

  modport slave (
    input  in_values, in_valid, out_ready,
    output in_ready, out_values, out_valid, argmax_idx, max_value
  );
endinterface

// File: rtl/activation_quant.sv
// Activation + requantization stage following a fully-connected layer.
// Captures a packed vector of 2*DATAWIDTH pre-activations, walks it one row
// per cycle applying ReLU/identity, rounding right shift and saturation to
// DATAWIDTH, tracks the argmax of the quantized values, then holds the
// result until the consumer takes it.
module activation_quant #(
  parameter int ROWS       = 30,
  parameter int DATAWIDTH  = 11,
  parameter int FRAC_SHIFT = 5,
  parameter int ACT_RELU   = 1
) (
  input  logic                clk,
  input  logic                rst_overall,
  input  logic                rst_vals,
  activation_quant_if.slave   bus
);
  localparam int IN_W  = 2 * DATAWIDTH;
  localparam int EXT_W = IN_W + 1;
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  // Row counter needs one code beyond the last row: it marks the drain cycle
  // between the final row write and presenting the result.
  localparam int ROW_W = $clog2(ROWS + 1);
  localparam logic [ROW_W-1:0] ROW_END = ROW_W'(ROWS);

  // Rounding constant: half an LSB of the shifted result.
  localparam logic signed [EXT_W-1:0] RND =
    EXT_W'((FRAC_SHIFT > 0) ? (1 << ((FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0)) : 0);
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (DATAWIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(1 << (DATAWIDTH - 1)));
  localparam logic signed [DATAWIDTH-1:0] OUT_MAX = {1'b0, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [DATAWIDTH-1:0] OUT_MIN = {1'b1, {(DATAWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    PROCESS,
    HOLD
  } state_t;

  state_t                       state_reg;
  state_t                       state_next;
  logic [ROW_W-1:0]             row_reg;
  logic [IDX_W-1:0]             row_idx;
  logic signed [IN_W-1:0]       buf_mem [ROWS];
  logic signed [DATAWIDTH-1:0]  out_mem [ROWS];
  logic [IDX_W-1:0]             argmax_reg;
  logic signed [DATAWIDTH-1:0]  max_reg;
  logic signed [DATAWIDTH-1:0]  row_q;
  logic                         row_done;
  logic                         capture;
  logic                         step;
  logic                         in_ready_c;
  logic                         out_valid_c;

  // ReLU/identity, rounding arithmetic shift and saturation of one element.
  // The extra bit keeps the rounding add from overflowing.
  function automatic logic signed [DATAWIDTH-1:0] quantize(input logic signed [IN_W-1:0] x);
    logic signed [EXT_W-1:0] a;
    logic signed [EXT_W-1:0] s;
    logic signed [DATAWIDTH-1:0] r;
    a = {x[IN_W-1], x};
    if ((ACT_RELU != 0) && x[IN_W-1]) begin
      a = '0;
    end
    if (FRAC_SHIFT > 0) begin
      s = (a + RND) >>> FRAC_SHIFT;
    end else begin
      s = a;
    end
    r = s[DATAWIDTH-1:0];
    if (s > SAT_MAX) begin
      r = OUT_MAX;
    end else if (s < SAT_MIN) begin
      r = OUT_MIN;
    end
    return r;
  endfunction

  assign row_idx  = row_reg[IDX_W-1:0];
  assign row_done = (row_reg == ROW_END);
  assign capture  = (state_reg == IDLE) && bus.in_valid;
  assign step     = (state_reg == PROCESS) && !row_done;
  assign row_q    = quantize(buf_mem[row_idx]);

  // State register; either reset returns to IDLE and abandons any vector.
  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      state_reg <= IDLE;
    end else if (rst_vals) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs; in_valid is only honoured in IDLE.
  always_comb begin
    state_next  = state_reg;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_next = PROCESS;
        end
      end
      PROCESS: begin
        if (row_done) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;

  // Row counter and running max; row 0 seeds the max, later rows replace it
  // only when strictly greater so ties keep the lowest index.
  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      row_reg    <= '0;
      argmax_reg <= '0;
      max_reg    <= '0;
    end else if (rst_vals) begin
      row_reg    <= '0;
      argmax_reg <= '0;
      max_reg    <= '0;
    end else if (capture) begin
      row_reg <= '0;
    end else if (step) begin
      row_reg <= row_reg + 1'b1;
      if ((row_idx == '0) || (row_q > max_reg)) begin
        argmax_reg <= row_idx;
        max_reg    <= row_q;
      end
    end
  end

  assign bus.argmax_idx = argmax_reg;
  assign bus.max_value  = max_reg;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    // Input buffer element: sampled only on the acceptance edge.
    always_ff @(posedge clk or posedge rst_overall) begin
      if (rst_overall) begin
        buf_mem[gi] <= '0;
      end else if (rst_vals) begin
        buf_mem[gi] <= '0;
      end else if (capture) begin
        buf_mem[gi] <= bus.in_values[(ROWS-gi-1)*IN_W +: IN_W];
      end
    end

    // Result element: written on the cycle the row counter points at it.
    always_ff @(posedge clk or posedge rst_overall) begin
      if (rst_overall) begin
        out_mem[gi] <= '0;
      end else if (rst_vals) begin
        out_mem[gi] <= '0;
      end else if (step && (row_idx == IDX_W'(gi))) begin
        out_mem[gi] <= row_q;
      end
    end

    assign bus.out_values[(ROWS-gi-1)*DATAWIDTH +: DATAWIDTH] = out_mem[gi];
  end
endmodule
